// File: rtl/fib_bcd_converter.sv
// fib_bcd_converter: iterative double-dabble binary-to-BCD stage
// with a one-entry pending buffer and a valid/ready output.
module fib_bcd_converter #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy,
  output logic                  drop_err
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] bin_q;
  logic [DATA_W-1:0] pend_q;
  logic              pend_vld_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_adj;
  logic [BW-1:0]     bcd_d;
  logic [CW-1:0]     cnt_q;
  logic              out_valid_q;
  logic [BW-1:0]     out_bcd_q;
  logic              drop_q;
  logic              take;
  logic              direct;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i+:4] >= 4'd5) begin
        bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
      end
    end
    bcd_d = {bcd_adj[BW-2:0], bin_q[DATA_W-1]};
  end

  // take: the pending slot is emptied into the shifter this edge
  assign take = pend_vld_q &&
                ((state_q == IDLE) ||
                 ((state_q == DONE) && out_ready));
  assign direct = (state_q == IDLE) && !pend_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      drop_q      <= 1'b0;
    end else begin
      if (in_valid && !direct) begin
        if (!pend_vld_q || take) begin
          pend_q     <= in_data;
          pend_vld_q <= 1'b1;
        end else begin
          drop_q <= 1'b1;
        end
      end else if (take) begin
        pend_vld_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (pend_vld_q) begin
            bin_q   <= pend_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end else if (in_valid) begin
            bin_q   <= in_data;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= {bin_q[DATA_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_W - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            out_bcd_q   <= bcd_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (pend_vld_q) begin
              bin_q   <= pend_q;
              bcd_q   <= '0;
              cnt_q   <= '0;
              state_q <= SHIFT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign busy      = (state_q != IDLE);
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_fib_bcd_converter.sv
// tb_fib_bcd_converter: randomized and directed checks of the
// BCD converter against an arithmetic decimal-digit model.
module tb_fib_bcd_converter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [11:0] out_bcd;
  logic        busy;
  logic        drop_err;

  int tests = 0;
  int fails = 0;

  int          pk[$];
  int          pv[$];
  logic [11:0] acc_v[$];
  int          acc_k[$];
  logic        dh[64];

  fib_bcd_converter #(.DATA_W(8), .DIGITS(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bcd(out_bcd),
    .busy(busy),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 ||
        drop_err !== 1'b0 || out_bcd !== 12'h000) begin
      fails++;
      $display("FAIL reset: valid=%b busy=%b drop=%b bcd=%h want 0 0 0 000",
               out_valid, busy, drop_err, out_bcd);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b want 0 0",
               busy, out_valid);
    end
  endtask

  task automatic convert(input int v);
    int  k;
    bit  seen;
    seen = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'(v);
    step();
    in_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      step();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen || k != 8) begin
      fails++;
      $display("FAIL latency(%0d): got %0d cycles seen=%0d want 8",
               v, k, seen);
    end
    tests++;
    if (out_bcd !== ref_bcd(v)) begin
      fails++;
      $display("FAIL bcd(%0d): got %h want %h", v, out_bcd, ref_bcd(v));
    end
    step();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL handshake(%0d): valid=%b busy=%b want 0 0",
               v, out_valid, busy);
    end
  endtask

  task automatic test_basic();
    convert(55);
  endtask

  task automatic test_boundaries();
    convert(0);
    convert(255);
    convert(233);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) convert(int'($urandom_range(0, 255)));
  endtask

  task automatic test_backpressure();
    int  k;
    bit  seen;
    seen = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd89;
    step();
    in_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      step();
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests++;
    if (!seen || k != 8) begin
      fails++;
      $display("FAIL bp_latency: got %0d seen=%0d want 8", k, seen);
    end
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_bcd !== 12'h089) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%b bcd=%h want 1 089",
                 i, out_valid, out_bcd);
      end
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: valid=%b busy=%b want 0 0",
               out_valid, busy);
    end
  endtask

  // Drive the pulse schedule in pk/pv, raise out_ready from step rk,
  // and log every accepted transfer with the edge index it happened at.
  task automatic run_sched(input int rk, input int n);
    acc_v.delete();
    acc_k.delete();
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      foreach (pk[i]) begin
        if (pk[i] == k) begin
          in_valid = 1'b1;
          in_data = 8'(pv[i]);
        end
      end
      out_ready = (k >= rk);
      if (out_valid && out_ready) begin
        acc_v.push_back(out_bcd);
        acc_k.push_back(k);
      end
      step();
      dh[k] = drop_err;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_pending(input int a, input int b, input int gap,
                              input int k2);
    pk = '{0, gap};
    pv = '{a, b};
    run_sched(0, 32);
    tests++;
    if (acc_v.size() != 2) begin
      fails++;
      $display("FAIL pend_count(gap %0d): got %0d want 2",
               gap, acc_v.size());
    end else begin
      tests++;
      if (acc_v[0] !== ref_bcd(a) || acc_v[1] !== ref_bcd(b)) begin
        fails++;
        $display("FAIL pend_order: got %h %h want %h %h",
                 acc_v[0], acc_v[1], ref_bcd(a), ref_bcd(b));
      end
      tests++;
      if (acc_k[0] != 9 || acc_k[1] != k2) begin
        fails++;
        $display("FAIL pend_timing(gap %0d): got %0d %0d want 9 %0d",
                 gap, acc_k[0], acc_k[1], k2);
      end
    end
    tests++;
    if (drop_err !== 1'b0) begin
      fails++;
      $display("FAIL pend_drop: got %b want 0", drop_err);
    end
  endtask

  task automatic test_back_to_back();
    int a, b, c;
    a = int'($urandom_range(0, 255));
    b = int'($urandom_range(0, 255));
    c = int'($urandom_range(0, 255));
    pk = '{0, 2, 12};
    pv = '{a, b, c};
    run_sched(12, 40);
    tests++;
    if (acc_v.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d want 3", acc_v.size());
    end else begin
      tests++;
      if (acc_v[0] !== ref_bcd(a) || acc_v[1] !== ref_bcd(b) ||
          acc_v[2] !== ref_bcd(c)) begin
        fails++;
        $display("FAIL b2b_order: got %h %h %h want %h %h %h",
                 acc_v[0], acc_v[1], acc_v[2],
                 ref_bcd(a), ref_bcd(b), ref_bcd(c));
      end
      tests++;
      if (acc_k[0] != 12 || acc_k[1] != 21 || acc_k[2] != 30) begin
        fails++;
        $display("FAIL b2b_timing: got %0d %0d %0d want 12 21 30",
                 acc_k[0], acc_k[1], acc_k[2]);
      end
    end
    tests++;
    if (drop_err !== 1'b0) begin
      fails++;
      $display("FAIL b2b_drop: got %b want 0", drop_err);
    end
  endtask

  task automatic test_overflow();
    pk = '{0, 2, 4};
    pv = '{1, 2, 3};
    run_sched(12, 40);
    tests++;
    if (acc_v.size() != 2) begin
      fails++;
      $display("FAIL ovf_count: got %0d want 2", acc_v.size());
    end else begin
      tests++;
      if (acc_v[0] !== 12'h001 || acc_v[1] !== 12'h002) begin
        fails++;
        $display("FAIL ovf_order: got %h %h want 001 002",
                 acc_v[0], acc_v[1]);
      end
    end
    tests++;
    if (dh[3] !== 1'b0 || dh[4] !== 1'b1 || dh[39] !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drop: got k3=%b k4=%b k39=%b want 0 1 1",
               dh[3], dh[4], dh[39]);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 8'd144;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || drop_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b busy=%b drop=%b want 0 0 0",
               out_valid, busy, drop_err);
    end
    step();
    rst_n = 1'b1;
    step();
    convert(8);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_random();
    test_backpressure();
    test_pending(34, 21, 3, 18);
    test_pending(int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)),
                 int'($urandom_range(1, 8)), 18);
    test_pending(int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), 9, 19);
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
